// File: rtl/package_settings.sv
// Project-wide data widths shared by the ADC front end and the filter chain.
package package_settings;
  localparam int SIZE_ADC_DATA    = 14;
  localparam int SIZE_FILTER_DATA = 16;
endpackage

// File: rtl/trap_filter_pkg.sv
// Trapezoidal filter constants, reset defaults and fill-state encoding.
package trap_filter_pkg;
  localparam int MAX_DEPTH = 64;
  localparam int ACC_GUARD = 16;
  localparam int DEF_K     = 4;
  localparam int DEF_L     = 8;
  localparam int DEF_M     = 16;
  localparam int DEF_SHIFT = 4;
  localparam int PIPE_LAT  = 6;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } fill_state_t;
endpackage

// File: rtl/trap_delay_line.sv
// Circular sample buffer with taps at k, l and k+l behind the incoming sample;
// taps reaching past the samples written since the last clear read as zero.
module trap_delay_line #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 14,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    wr_en,
  input  logic signed [WIDTH-1:0] wr_data,
  input  logic        [CW-1:0]    k,
  input  logic        [CW-1:0]    l,
  output logic signed [WIDTH-1:0] tap_k,
  output logic signed [WIDTH-1:0] tap_l,
  output logic signed [WIDTH-1:0] tap_kl
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW = CW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [CW-1:0]    count;
  logic [SW-1:0]    off_k;
  logic [SW-1:0]    off_l;
  logic [SW-1:0]    off_kl;

  // Offset DEPTH lands on wptr itself, read before this cycle's write.
  function automatic logic [PW-1:0] rd_idx(input logic [PW-1:0] p, input logic [SW-1:0] off);
    logic [SW-1:0] t;
    t = SW'(p) + SW'(DEPTH) - off;
    if (t >= SW'(DEPTH)) t = t - SW'(DEPTH);
    return PW'(t);
  endfunction

  always_comb begin
    off_k  = SW'(k);
    off_l  = SW'(l);
    off_kl = off_k + off_l;
    tap_k  = (!clear && off_k  <= SW'(count)) ? mem[rd_idx(wptr, off_k)]  : '0;
    tap_l  = (!clear && off_l  <= SW'(count)) ? mem[rd_idx(wptr, off_l)]  : '0;
    tap_kl = (!clear && off_kl <= SW'(count)) ? mem[rd_idx(wptr, off_kl)] : '0;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      count <= '0;
    end else begin
      if (wr_en) wptr <= (wptr == PW'(DEPTH - 1)) ? '0 : wptr + PW'(1);
      if (clear)
        count <= wr_en ? CW'(1) : '0;
      else if (wr_en && count != CW'(DEPTH))
        count <= count + CW'(1);
    end
  end
endmodule

// File: rtl/trap_filter_cfg.sv
// Runtime-configurable trapezoidal shaper with pole-zero correction,
// six-stage pipeline, saturated output and FILL/RUN tracking of the delay line.
module trap_filter_cfg
  import package_settings::*;
  import trap_filter_pkg::fill_state_t;
  import trap_filter_pkg::FILL;
  import trap_filter_pkg::RUN;
#(
  parameter int MAX_DEPTH = trap_filter_pkg::MAX_DEPTH,
  parameter int ACC_GUARD = trap_filter_pkg::ACC_GUARD,
  parameter int DEF_K     = trap_filter_pkg::DEF_K,
  parameter int DEF_L     = trap_filter_pkg::DEF_L,
  parameter int DEF_M     = trap_filter_pkg::DEF_M,
  parameter int DEF_SHIFT = trap_filter_pkg::DEF_SHIFT
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               in_valid,
  input  logic signed [SIZE_ADC_DATA-1:0]    input_data,
  input  logic                               cfg_load,
  input  logic [$clog2(MAX_DEPTH+1)-1:0]     cfg_k,
  input  logic [$clog2(MAX_DEPTH+1)-1:0]     cfg_l,
  input  logic [15:0]                        cfg_m,
  input  logic [4:0]                         cfg_shift,
  output logic                               cfg_err,
  output logic                               filling,
  output logic                               out_valid,
  output logic signed [SIZE_FILTER_DATA-1:0] output_data,
  output logic                               sat_flag
);
  localparam int CW    = $clog2(MAX_DEPTH + 1);
  localparam int SW    = CW + 1;
  localparam int ACC_W = SIZE_ADC_DATA + ACC_GUARD;
  localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'(2 ** (SIZE_FILTER_DATA - 1) - 1);
  localparam logic signed [ACC_W-1:0] OUT_MIN = ACC_W'(-(2 ** (SIZE_FILTER_DATA - 1)));

  logic [CW-1:0] k_r, l_r;
  logic [15:0]   m_r;
  logic [4:0]    shift_r;

  logic [SW-1:0] cfg_sum, kl_sum;
  logic          cfg_fields_ok, cfg_ok;

  fill_state_t   state_q, state_d;
  logic [CW-1:0] fill_cnt, fill_d;

  logic signed [SIZE_ADC_DATA-1:0] tap_k, tap_l, tap_kl;
  logic signed [ACC_W-1:0] x_ext, tk_ext, tl_ext, tkl_ext, m_ext;
  logic signed [ACC_W-1:0] d1, d2, d, p, md, r, s, shifted;
  logic                    v1, v2, v3, v4, v5;
  logic                    sat_hi, sat_lo;
  logic signed [SIZE_FILTER_DATA-1:0] y;

  always_comb begin
    cfg_sum       = SW'(cfg_k) + SW'(cfg_l);
    cfg_fields_ok = (cfg_k != '0) && (cfg_l != '0) && (cfg_sum <= SW'(MAX_DEPTH));
    cfg_ok        = cfg_load && cfg_fields_ok;
    kl_sum        = SW'(k_r) + SW'(l_r);
  end

  trap_delay_line #(
    .DEPTH (MAX_DEPTH),
    .WIDTH (SIZE_ADC_DATA),
    .CW    (CW)
  ) u_delay (
    .clk     (clk),
    .reset   (reset),
    .clear   (cfg_ok),
    .wr_en   (in_valid),
    .wr_data (input_data),
    .k       (k_r),
    .l       (l_r),
    .tap_k   (tap_k),
    .tap_l   (tap_l),
    .tap_kl  (tap_kl)
  );

  always_comb begin
    x_ext   = ACC_W'(input_data);
    tk_ext  = ACC_W'(tap_k);
    tl_ext  = ACC_W'(tap_l);
    tkl_ext = ACC_W'(tap_kl);
    m_ext   = ACC_W'($signed({1'b0, m_r}));
    shifted = s >>> shift_r;
    sat_hi  = shifted > OUT_MAX;
    sat_lo  = shifted < OUT_MIN;
    y       = shifted[SIZE_FILTER_DATA-1:0];
    if (sat_hi) y = SIZE_FILTER_DATA'(OUT_MAX);
    if (sat_lo) y = SIZE_FILTER_DATA'(OUT_MIN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      k_r     <= CW'(DEF_K);
      l_r     <= CW'(DEF_L);
      m_r     <= 16'(DEF_M);
      shift_r <= 5'(DEF_SHIFT);
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_load && !cfg_fields_ok;
      if (cfg_ok) begin
        k_r     <= cfg_k;
        l_r     <= cfg_l;
        m_r     <= cfg_m;
        shift_r <= cfg_shift;
      end
    end
  end

  // A sample arriving with an accepted cfg_load enters stage 1 (taps masked by
  // the clear) while everything downstream is flushed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      {v1, v2, v3, v4, v5} <= '0;
      d1          <= '0;
      d2          <= '0;
      d           <= '0;
      p           <= '0;
      md          <= '0;
      r           <= '0;
      s           <= '0;
      out_valid   <= 1'b0;
      output_data <= '0;
      sat_flag    <= 1'b0;
    end else begin
      v1 <= in_valid;
      if (in_valid) begin
        d1 <= x_ext - tk_ext;
        d2 <= tl_ext - tkl_ext;
      end
      if (cfg_ok) begin
        {v2, v3, v4, v5} <= '0;
        out_valid        <= 1'b0;
        p                <= '0;
        s                <= '0;
      end else begin
        v2        <= v1;
        v3        <= v2;
        v4        <= v3;
        v5        <= v4;
        out_valid <= v5;
        if (v1) d <= d1 - d2;
        if (v2) begin
          p  <= p + d;
          md <= m_ext * d;
        end
        if (v3) r <= p + md;
        if (v4) s <= s + r;
        if (v5) begin
          output_data <= y;
          sat_flag    <= sat_hi || sat_lo;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= FILL;
      fill_cnt <= '0;
    end else begin
      state_q  <= state_d;
      fill_cnt <= fill_d;
    end
  end

  always_comb begin
    state_d = state_q;
    fill_d  = fill_cnt;
    if (cfg_ok) begin
      state_d = FILL;
      fill_d  = in_valid ? CW'(1) : '0;
    end else if (state_q == FILL && in_valid) begin
      fill_d = fill_cnt + CW'(1);
      if (SW'(fill_d) >= kl_sum) state_d = RUN;
    end
  end

  assign filling = (state_q == FILL);
endmodule

// File: doc/trap_filter_cfg.md
TRAP_FILTER_CFG -- requirements
Module: trap_filter_cfg

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  MAX_DEPTH, 64, maximum k+l delay-line depth.
  ACC_GUARD, 16, accumulator guard bits above SIZE_ADC_DATA.
  DEF_K, 4, post-reset k. DEF_L, 8, post-reset l. DEF_M, 16, post-reset M. DEF_SHIFT, 4, post-reset output shift.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk  in  1  single clock, rising edge.
  reset  in  1  asynchronous, active-low reset.
  in_valid  in  1  input_data holds a sample this cycle.
  input_data  in  SIZE_ADC_DATA  signed ADC sample.
  cfg_load  in  1  one-cycle strobe to apply cfg_*.
  cfg_k, cfg_l  in  clog2(MAX_DEPTH+1) each  unsigned rise/flat lengths.
  cfg_m  in  16  unsigned pole-zero multiplier M.
  cfg_shift  in  5  arithmetic right shift applied to the output.
  cfg_err  out  1  one-cycle pulse: cfg_load rejected.
  filling  out  1  delay line holds fewer than k+l samples under current config.
  out_valid  out  1  output_data holds a new result.
  output_data  out  SIZE_FILTER_DATA  signed, saturated filter output.
  sat_flag  out  1  output_data was clamped this result.

Function
REQ-003 Per accepted sample x[n]: D1=x[n]-x[n-k]; D2=x[n-l]-x[n-k-l]; D=D1-D2; P+=D; R=P+M*D; S+=R; y=sat(S>>>shift).
REQ-004 Internal width ACC_W=SIZE_ADC_DATA+ACC_GUARD; input sign-extended; all arithmetic signed two's complement, wrapping at ACC_W.
REQ-005 Pipeline: taps/D1,D2 -> D -> P,M*D -> R -> S -> output register; out_valid SHALL assert exactly 6 clocks after the in_valid cycle, one result per accepted sample.
REQ-006 Stages SHALL advance only with their valid bit; idle cycles (in_valid=0) leave P, S and outputs unchanged; output_data holds its last value.
REQ-007 Taps older than the samples written since the last reset/cfg_load SHALL read as zero.
REQ-008 State machine FILL/RUN: FILL after reset or accepted cfg_load; FILL->RUN when k+l samples accepted; filling=1 iff FILL; results are still produced in FILL.
REQ-009 cfg_load accepted iff 1<=cfg_k, 1<=cfg_l, cfg_k+cfg_l<=MAX_DEPTH; otherwise cfg_err pulses next cycle and config/state are unchanged.
REQ-010 Accepted cfg_load SHALL: latch cfg_*, clear P, S, all stage valids and the fill count; in-flight results are discarded (no out_valid for them).
REQ-011 in_valid coincident with accepted cfg_load: sample is the first sample under the new config.
REQ-012 Saturation: if S>>>shift exceeds the SIZE_FILTER_DATA signed range, output clamps to max/min and sat_flag=1 with that out_valid; else sat_flag=0.
REQ-013 Delay-line write pointer SHALL wrap modulo MAX_DEPTH; tap reads use modular subtraction.

Reset
REQ-014 reset=0 SHALL asynchronously clear: out_valid, cfg_err, sat_flag, output_data=0, P, S, all stage registers and valids, write pointer, fill count.
REQ-015 Under reset, config SHALL load DEF_K, DEF_L, DEF_M, DEF_SHIFT and state SHALL be FILL (filling=1).
REQ-016 Reset mid-stream SHALL discard all in-flight samples; no out_valid until 6 clocks after the first post-reset in_valid.

Structure
REQ-017 SIZE_ADC_DATA and SIZE_FILTER_DATA SHALL come from package_settings.
REQ-018 A new package trap_filter_pkg SHALL hold MAX_DEPTH, ACC_GUARD, the DEF_* values, the FILL/RUN state enum and the pipeline latency constant (6).
REQ-019 One sub-module, trap_delay_line: circular buffer of MAX_DEPTH with write port and taps at offsets k, l, k+l plus zero-masking of unwritten taps.

Verification
REQ-020 Impulse 16 then zeros, k=2, l=3, M=0, shift=0 -> outputs 16,32,32,16,0,0 starting 6 clocks after the impulse.
REQ-021 Constant max-positive input, M=65535, shift=0 -> output clamps to SIZE_FILTER_DATA max with sat_flag=1.
REQ-022 cfg_load with cfg_k=0 (or k+l=MAX_DEPTH+1) -> cfg_err one-cycle pulse, outputs continue under old config.
REQ-023 Valid cfg_load during continuous stream -> no out_valid for 5 in-flight samples, filling=1 for exactly k+l accepted samples.
REQ-024 reset=0 asserted mid-stream between clock edges -> all outputs 0 immediately; filling=1; defaults active after release.
REQ-025 in_valid toggled randomly vs. continuous stream of same samples -> identical output sequence.
